coop_comm_rx: RTL and testbench

Receive-side decoder for the co-op position link. It pops bytes from the UART receive FIFO and parses the ASCII packet `P:dddd\r\n` (four decimal digits, most significant first). Each well-formed, in-range packet updates a registered 12-bit partner X position. It sits between the UART RX FIFO and the game logic, and also reports malformed packets and link loss.

---
 rtl/coop_comm_pkg.sv | 17 +
 rtl/coop_comm_rx_if.sv | 8 +
 rtl/coop_link_timer.sv | 16 +
 rtl/coop_comm_rx.sv | 109 ++++++++++
 tb/tb_coop_comm_rx.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/coop_comm_pkg.sv
// coop_comm_pkg: framing constants and parser states shared by both ends of the co-op position link
package coop_comm_pkg;
  localparam logic [7:0] CH_P     = 8'h50;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam int PKT_DIGITS = 4;
  typedef enum logic [2:0] {
    S_WAIT_P,
    S_WAIT_COLON,
    S_DIGIT,
    S_WAIT_CR,
    S_WAIT_LF
  } coop_rx_state_t;
endpackage

// File: rtl/coop_comm_rx_if.sv
// coop_comm_rx_if: UART RX FIFO read port as seen by the packet decoder
interface coop_comm_rx_if;
  logic       rx_empty;
  logic [7:0] r_data;
  logic       rd_uart;
  modport master (output rx_empty, r_data, input rd_uart);
  modport slave (input rx_empty, r_data, output rd_uart);
endinterface

// File: rtl/coop_link_timer.sv
// coop_link_timer: restartable timeout counter that saturates at CYCLES; expired while saturated
module coop_link_timer #(
  parameter int CYCLES = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic expired
);
  localparam int W = $clog2(CYCLES + 1);
  localparam logic [W-1:0] TC = W'(CYCLES);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= rst ? TC : restart ? '0 : (cnt == TC) ? cnt : cnt + W'(1);
  assign expired = cnt == TC;
endmodule

// File: rtl/coop_comm_rx.sv
// coop_comm_rx: pops FIFO bytes, decodes "P:dddd\r\n" into a 12-bit partner position, flags bad packets and link loss
module coop_comm_rx
  import coop_comm_pkg::*;
#(
  parameter int FCLK_HZ    = 100_000_000,
  parameter int TIMEOUT_MS = 200,
  parameter int MAX_XPOS   = 4095
) (
  input  logic              clk,
  input  logic              rst,
  coop_comm_rx_if.slave     fifo,
  output logic [11:0]       coop_xpos,
  output logic              coop_valid,
  output logic              pkt_err,
  output logic              link_alive
);
  localparam logic [13:0] MAX_ACC    = 14'(MAX_XPOS);
  localparam logic [1:0]  LAST_DIGIT = 2'(PKT_DIGITS - 1);
  coop_rx_state_t state, state_d;
  logic [7:0]  byte_q;
  logic        byte_vld;
  logic [13:0] acc, acc_d, acc_next;
  logic [1:0]  dcnt, dcnt_d;
  logic        valid_d, err_d, bad, is_digit, expired;
  logic        fetch;
  // rd_uart gates the next fetch so a byte is never popped twice
  assign fetch = !fifo.rx_empty && !fifo.rd_uart;
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo.rd_uart <= 1'b0;
      byte_vld     <= 1'b0;
      byte_q       <= '0;
    end else begin
      fifo.rd_uart <= fetch;
      byte_vld     <= fetch;
      if (fetch) byte_q <= fifo.r_data;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_WAIT_P;
      acc        <= '0;
      dcnt       <= '0;
      coop_xpos  <= '0;
      coop_valid <= 1'b0;
      pkt_err    <= 1'b0;
    end else begin
      state      <= state_d;
      acc        <= acc_d;
      dcnt       <= dcnt_d;
      coop_valid <= valid_d;
      pkt_err    <= err_d;
      if (valid_d) coop_xpos <= acc[11:0];
    end
  end
  assign is_digit = byte_q >= CH_0 && byte_q <= CH_9;
  assign acc_next = (acc << 3) + (acc << 1) + {10'd0, byte_q[3:0]};
  always_comb begin
    state_d = state;
    acc_d   = acc;
    dcnt_d  = dcnt;
    valid_d = 1'b0;
    err_d   = 1'b0;
    bad     = 1'b0;
    if (byte_vld) begin
      case (state)
        S_WAIT_P:     state_d = byte_q == CH_P ? S_WAIT_COLON : S_WAIT_P;
        S_WAIT_COLON: begin
          bad     = byte_q != CH_COLON;
          acc_d   = '0;
          dcnt_d  = '0;
          state_d = S_DIGIT;
        end
        S_DIGIT: begin
          bad     = !is_digit;
          acc_d   = acc_next;
          dcnt_d  = dcnt + 2'd1;
          state_d = dcnt == LAST_DIGIT ? S_WAIT_CR : S_DIGIT;
        end
        S_WAIT_CR: begin
          bad     = byte_q != CH_CR;
          state_d = S_WAIT_LF;
        end
        S_WAIT_LF: begin
          bad     = byte_q != CH_LF;
          valid_d = byte_q == CH_LF && acc <= MAX_ACC;
          err_d   = byte_q == CH_LF && acc > MAX_ACC;
          state_d = S_WAIT_P;
        end
        default: state_d = S_WAIT_P;
      endcase
      // a stray 'P' mid-packet is taken as the start of a fresh packet
      if (bad) begin
        err_d   = 1'b1;
        valid_d = 1'b0;
        acc_d   = '0;
        dcnt_d  = '0;
        state_d = byte_q == CH_P ? S_WAIT_COLON : S_WAIT_P;
      end
    end
  end
  coop_link_timer #(.CYCLES(TIMEOUT_MS * (FCLK_HZ / 1000))) u_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (valid_d),
    .expired (expired)
  );
  assign link_alive = !expired;
endmodule

// File: tb/tb_coop_comm_rx.sv
// tb_coop_comm_rx: directed and randomized byte streams checked against a template-matching packet model
module tb_coop_comm_rx;
  localparam int TMO  = 10;
  localparam int MAXX = 4095;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  coop_comm_rx_if fif();
  logic [11:0] coop_xpos;
  logic        coop_valid, pkt_err, link_alive;
  coop_comm_rx #(.FCLK_HZ(10_000), .TIMEOUT_MS(1), .MAX_XPOS(MAXX)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo       (fif.slave),
    .coop_xpos  (coop_xpos),
    .coop_valid (coop_valid),
    .pkt_err    (pkt_err),
    .link_alive (link_alive)
  );
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] q[$];
  logic [7:0] ms[$];
  int obs[$];
  int exp_ev[$];
  int rises[$];
  bit throttle = 1'b0;
  bit have_valid = 1'b0;
  bit link_prev = 1'b0;
  int last_v = -100;
  int fall_cyc = -1;
  int exp_x = 0;
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, o, e);
    end
  endtask
  task automatic step();
    logic rd_prev;
    rd_prev = fif.rd_uart;
    @(posedge clk);
    #1;
    cyc++;
    if (rd_prev === 1'b1 && q.size() > 0) q.delete(0);
    if (fif.rd_uart === 1'b1 && rd_prev !== 1'b1) rises.push_back(cyc);
    if (coop_valid === 1'b1) begin
      obs.push_back(int'(coop_xpos));
      have_valid = 1'b1;
      last_v = cyc;
    end
    if (pkt_err === 1'b1) obs.push_back(-1);
    chk("valid_err_overlap", 32'(coop_valid & pkt_err), 0);
    chk("link_alive", 32'(link_alive), 32'(have_valid && (cyc - last_v) < TMO));
    if (link_prev && link_alive === 1'b0) fall_cyc = cyc;
    link_prev = link_alive === 1'b1;
    fif.rx_empty = q.size() == 0 || (throttle && $urandom_range(0, 1) == 1);
    fif.r_data = q.size() > 0 ? q[0] : 8'h00;
  endtask
  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) begin
      q.push_back(s[i]);
      ms.push_back(s[i]);
    end
  endtask
  function automatic bit tmatch(input int k, input logic [7:0] b);
    if (k == 1) return b == 8'h3A;
    if (k <= 5) return b >= 8'h30 && b <= 8'h39;
    if (k == 6) return b == 8'h0D;
    return b == 8'h0A;
  endfunction
  // Scan the stream since the last reset for whole "P:dddd\r\n" matches
  task automatic model();
    int i, k, v, n;
    exp_ev.delete();
    exp_x = 0;
    i = 0;
    n = ms.size();
    while (i < n) begin
      if (ms[i] != 8'h50) begin
        i++;
      end else begin
        k = 1;
        while (k < 8 && i + k < n && tmatch(k, ms[i+k])) k++;
        if (k == 8) begin
          v = 0;
          for (int d = 2; d <= 5; d++) v = v * 10 + int'(ms[i+d]) - 48;
          if (v <= MAXX) begin
            exp_ev.push_back(v);
            exp_x = v;
          end else exp_ev.push_back(-1);
          i += 8;
        end else if (i + k >= n) begin
          i = n;
        end else begin
          exp_ev.push_back(-1);
          i = (ms[i+k] == 8'h50) ? i + k : i + k + 1;
        end
      end
    end
  endtask
  task automatic drain(input string tag);
    int b = 0;
    while ((q.size() > 0 || fif.rd_uart === 1'b1) && b < 3000) begin
      step();
      b++;
    end
    chk({tag, "_drain"}, q.size(), 0);
    repeat (TMO + 2) step();
    model();
    chk({tag, "_nevents"}, obs.size(), exp_ev.size());
    for (int i = 0; i < exp_ev.size() && i < obs.size(); i++)
      chk($sformatf("%s_ev%0d", tag, i), obs[i], exp_ev[i]);
    chk({tag, "_xpos"}, 32'(coop_xpos), exp_x);
  endtask
  task automatic do_reset();
    have_valid = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    ms.delete();
    obs.delete();
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_uart"}, 32'(fif.rd_uart), 0);
    chk({tag, "_xpos"}, 32'(coop_xpos), 0);
    chk({tag, "_valid"}, 32'(coop_valid), 0);
    chk({tag, "_err"}, 32'(pkt_err), 0);
    chk({tag, "_link"}, 32'(link_alive), 0);
  endtask
  initial begin
    string s, cs;
    int kind, v, pos;
    fif.rx_empty = 1'b1;
    fif.r_data = 8'h00;
    cs = "P:09\015\012x5";
    do_reset();
    step();
    chk_reset_vals("reset");
    rises.delete();
    send("P:0123\015\012");
    drain("clean");
    chk("clean_rd_pulses", rises.size(), 8);
    for (int i = 1; i < rises.size(); i++)
      chk($sformatf("clean_rd_gap%0d", i), rises[i] - rises[i-1], 2);
    if (rises.size() > 0) chk("clean_latency", last_v - rises[rises.size()-1], 1);
    send("P:4095\015\012");
    drain("max");
    send("P:5000\015\012");
    drain("over");
    send("xxP:1P:0042\015\012");
    drain("resync");
    send("P:0007\012");
    drain("bad_term");
    send("P:0007\015\012");
    drain("good_term");
    fall_cyc = -1;
    send("P:0321\015\012");
    drain("timeout");
    chk("timeout_len", fall_cyc - last_v, TMO);
    chk("timeout_hold", 32'(coop_xpos), 321);
    throttle = 1'b1;
    send("P:0300\015\012");
    drain("throttle");
    throttle = 1'b0;
    send("P:03");
    drain("partial");
    do_reset();
    chk_reset_vals("midrst");
    send("00\015\012");
    drain("after_rst");
    chk_reset_vals("after_rst");
    throttle = 1'b1;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 4);
      if (kind <= 1) begin
        v = $urandom_range(0, MAXX);
        send($sformatf("P:%04d\015\012", v));
      end else if (kind == 2) begin
        v = $urandom_range(MAXX + 1, 9999);
        send($sformatf("P:%04d\015\012", v));
      end else if (kind == 3) begin
        s = $sformatf("P:%04d\015\012", $urandom_range(0, 9999));
        pos = $urandom_range(1, 7);
        s[pos] = cs[$urandom_range(0, cs.len() - 1)];
        send(s);
      end else begin
        s = "";
        repeat ($urandom_range(1, 6)) s = {s, " "};
        for (int i = 0; i < s.len(); i++) s[i] = cs[$urandom_range(0, cs.len() - 1)];
        send(s);
      end
      drain("rand");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
